// File: rtl/uart_rx_fifo_mon.sv
// UART receiver (configurable DATA_BITS/PARITY/STOP_BITS) with a character FIFO and sticky error flags.
// Latency: a character is in the FIFO on the final stop-bit sample, and rd_data/rd_valid follow rd_en by one cycle. When the FIFO is full, good characters are dropped and overrun is set.
module uart_rx_fifo_mon #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PRINT_EN   = 0,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          uart_rxd,
    input  logic          rd_en,
    input  logic          clr_err,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic [AW:0]   fifo_count,
    output logic          fifo_empty,
    output logic          fifo_full,
    output logic          uart_done,
    output logic [7:0]    uart_data,
    output logic          frame_err,
    output logic          parity_err,
    output logic          overrun
);
    localparam int BIT_CNT  = CLK_FREQ / BAUD;
    localparam int HALF_CNT = BIT_CNT / 2;
    localparam int CW       = $clog2(BIT_CNT + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP1, S_STOP2} state_t;

    state_t        state, state_nxt;
    logic          rxd_s1, rxd_s2, rxd_q;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          par_bad, par_bad_nxt, stop_bad, stop_bad_nxt;
    logic          tick, frame_done, exp_par;
    logic [7:0]    rx_char;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          wr_req, wr_en, pop;

    // Bits shift in from the top, so a short character ends up left-aligned.
    assign rx_char = shift >> (8 - DATA_BITS);
    assign exp_par = (^rx_char) ^ (PARITY == 1);
    assign tick    = (state == S_START) ? (cnt == CW'(HALF_CNT - 1))
                                        : (cnt == CW'(BIT_CNT - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_q    <= 1'b1;
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
        end else begin
            rxd_s1   <= uart_rxd;
            rxd_s2   <= rxd_s1;
            rxd_q    <= rxd_s2;
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            shift    <= shift_nxt;
            par_bad  <= par_bad_nxt;
            stop_bad <= stop_bad_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt + 1'b1;
        idx_nxt      = idx;
        shift_nxt    = shift;
        par_bad_nxt  = par_bad;
        stop_bad_nxt = stop_bad;
        frame_done   = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (rxd_q && !rxd_s2) begin
                    state_nxt    = S_START;
                    par_bad_nxt  = 1'b0;
                    stop_bad_nxt = 1'b0;
                end
            end
            S_START: if (tick) begin
                cnt_nxt   = '0;
                idx_nxt   = '0;
                state_nxt = rxd_s2 ? S_IDLE : S_DATA;
            end
            S_DATA: if (tick) begin
                cnt_nxt   = '0;
                shift_nxt = {rxd_s2, shift[7:1]};
                idx_nxt   = idx + 1'b1;
                if (idx == 3'(DATA_BITS - 1))
                    state_nxt = (PARITY != 0) ? S_PAR : S_STOP1;
            end
            S_PAR: if (tick) begin
                cnt_nxt     = '0;
                par_bad_nxt = (rxd_s2 != exp_par);
                state_nxt   = S_STOP1;
            end
            S_STOP1: if (tick) begin
                cnt_nxt      = '0;
                stop_bad_nxt = stop_bad | !rxd_s2;
                if (STOP_BITS == 2) begin
                    state_nxt = S_STOP2;
                end else begin
                    state_nxt  = S_IDLE;
                    frame_done = 1'b1;
                end
            end
            S_STOP2: if (tick) begin
                cnt_nxt      = '0;
                stop_bad_nxt = stop_bad | !rxd_s2;
                state_nxt    = S_IDLE;
                frame_done   = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign pop    = rd_en && (count != '0);
    assign wr_req = frame_done && !stop_bad_nxt;
    assign wr_en  = wr_req && (!fifo_full || pop);

    assign fifo_count = count;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));

    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[wr_ptr] <= rx_char;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            uart_done  <= 1'b0;
            uart_data  <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rd_valid  <= pop;
            uart_done <= frame_done;
            if (frame_done) uart_data <= rx_char;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new event wins over a simultaneous clear.
            frame_err  <= (frame_err  && !clr_err) || (frame_done && stop_bad_nxt);
            parity_err <= (parity_err && !clr_err) || (frame_done && par_bad);
            overrun    <= (overrun    && !clr_err) || (wr_req && fifo_full && !pop);
        end
    end

    generate
        if (PRINT_EN != 0) begin : g_print
            always @(posedge sys_clk) begin
                if (wr_en) $write("%c", rx_char);
            end
        end
    endgenerate
endmodule

// File: tb/tb_uart_rx_fifo_mon.sv
// Directed bench: three instances (8N1 at full rate, even parity with a depth-4 FIFO, 7-bit/2-stop with its own reset).
module tb_uart_rx_fifo_mon;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic rst_n = 1'b0, rst_c_n = 1'b0;
    logic rxd_a = 1'b1, rxd_b = 1'b1, rxd_c = 1'b1;
    logic rd_en_a = 1'b0, rd_en_b = 1'b0, rd_en_c = 1'b0;
    logic clr_a = 1'b0, clr_b = 1'b0, clr_c = 1'b0;

    logic [7:0] rd_data_a, rd_data_b, rd_data_c, udata_a, udata_b, udata_c;
    logic [4:0] cnt_a;
    logic [2:0] cnt_b;
    logic [4:0] cnt_c;
    logic rv_a, rv_b, rv_c, emp_a, emp_b, emp_c, full_a, full_b, full_c;
    logic done_a, done_b, done_c, ferr_a, ferr_b, ferr_c;
    logic perr_a, perr_b, perr_c, ovr_a, ovr_b, ovr_c;

    uart_rx_fifo_mon u_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd_a), .rd_en(rd_en_a), .clr_err(clr_a),
        .rd_data(rd_data_a), .rd_valid(rv_a), .fifo_count(cnt_a), .fifo_empty(emp_a),
        .fifo_full(full_a), .uart_done(done_a), .uart_data(udata_a), .frame_err(ferr_a),
        .parity_err(perr_a), .overrun(ovr_a));

    uart_rx_fifo_mon #(.CLK_FREQ(1600000), .BAUD(100000), .PARITY(2), .FIFO_DEPTH(4)) u_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd_b), .rd_en(rd_en_b), .clr_err(clr_b),
        .rd_data(rd_data_b), .rd_valid(rv_b), .fifo_count(cnt_b), .fifo_empty(emp_b),
        .fifo_full(full_b), .uart_done(done_b), .uart_data(udata_b), .frame_err(ferr_b),
        .parity_err(perr_b), .overrun(ovr_b));

    uart_rx_fifo_mon #(.CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(7), .STOP_BITS(2)) u_c (
        .sys_clk(clk), .sys_rst_n(rst_c_n), .uart_rxd(rxd_c), .rd_en(rd_en_c), .clr_err(clr_c),
        .rd_data(rd_data_c), .rd_valid(rv_c), .fifo_count(cnt_c), .fifo_empty(emp_c),
        .fifo_full(full_c), .uart_done(done_c), .uart_data(udata_c), .frame_err(ferr_c),
        .parity_err(perr_c), .overrun(ovr_c));

    // Monitors sample on the falling edge, away from DUT updates.
    int dn_a = 0, dn_b = 0, dn_c = 0;
    logic [7:0] q_a[$], q_b[$], q_c[$];
    always @(negedge clk) begin
        if (done_a) dn_a++;
        if (done_b) dn_b++;
        if (done_c) dn_c++;
        if (rv_a) q_a.push_back(rd_data_a);
        if (rv_b) q_b.push_back(rd_data_b);
        if (rv_c) q_c.push_back(rd_data_c);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [7:0] d, input int dbits, input int has_par,
                                       input logic par_bit, input int nstop, input logic stop_val);
        logic [15:0] b;
        int k;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < dbits; i++) b[1+i] = d[i];
        k = 1 + dbits;
        if (has_par != 0) begin
            b[k] = par_bit;
            k++;
        end
        for (int s = 0; s < nstop; s++) b[k+s] = stop_val;
        return b;
    endfunction

    task automatic set_rxd(input int inst, input logic v);
        case (inst)
            0: rxd_a = v;
            1: rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    // Called on a falling edge; each bit is held for cyc clocks.
    task automatic send(input int inst, input logic [15:0] bits, input int n, input int cyc);
        for (int i = 0; i < n; i++) begin
            set_rxd(inst, bits[i]);
            repeat (cyc) @(negedge clk);
        end
        set_rxd(inst, 1'b1);
    endtask

    task automatic pop(input int inst);
        case (inst)
            0: rd_en_a = 1'b1;
            1: rd_en_b = 1'b1;
            default: rd_en_c = 1'b1;
        endcase
        @(negedge clk);
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
        rd_en_c = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_b(input logic [7:0] d);
        send(1, mk(d, 8, 1, ^d, 1, 1'b1), 11, 16);
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        chk("rst_count_a", cnt_a, 0);
        chk("rst_empty_a", emp_a, 1);
        chk("rst_flags_a", {full_a, done_a, rv_a, ferr_a, perr_a, ovr_a}, 0);
        chk("rst_data_a", {rd_data_a, udata_a}, 0);
        rst_n = 1'b1;
        rst_c_n = 1'b1;
        repeat (3) @(negedge clk);

        // 8N1 back-to-back frames at 434 clocks per bit
        send(0, mk(8'h55, 8, 0, 1'b0, 1, 1'b1), 10, 434);
        send(0, mk(8'hA3, 8, 0, 1'b0, 1, 1'b1), 10, 434);
        repeat (5) @(negedge clk);
        chk("a_done2", dn_a, 2);
        chk("a_count2", cnt_a, 2);
        chk("a_udata", udata_a, 8'hA3);
        chk("a_noflags", {ferr_a, perr_a, ovr_a}, 0);
        pop(0);
        pop(0);
        chk("a_popn", q_a.size(), 2);
        chk("a_pop0", q_a[0], 8'h55);
        chk("a_pop1", q_a[1], 8'hA3);
        chk("a_count0", cnt_a, 0);
        chk("a_empty", emp_a, 1);
        pop(0);
        chk("a_pop_empty", q_a.size(), 2);

        // short low glitch is a false start
        rxd_a = 1'b0;
        repeat (3) @(negedge clk);
        rxd_a = 1'b1;
        repeat (400) @(negedge clk);
        chk("glitch_done", dn_a, 2);
        chk("glitch_flags", {ferr_a, perr_a, ovr_a}, 0);
        chk("glitch_empty", emp_a, 1);

        // stop bit low: frame error, character discarded
        send(0, mk(8'h41, 8, 0, 1'b0, 1, 1'b0), 10, 434);
        repeat (5) @(negedge clk);
        chk("ferr_done", dn_a, 3);
        chk("ferr_flag", ferr_a, 1);
        chk("ferr_count", cnt_a, 0);
        chk("ferr_udata", udata_a, 8'h41);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        @(negedge clk);
        chk("ferr_clr", ferr_a, 0);

        // even parity, wrong parity bit on 0x07 (three ones -> bit should be 1)
        send(1, mk(8'h07, 8, 1, 1'b0, 1, 1'b1), 11, 16);
        repeat (5) @(negedge clk);
        chk("par_flag", perr_b, 1);
        chk("par_count", cnt_b, 1);
        pop(1);
        chk("par_pop", q_b[0], 8'h07);
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        @(negedge clk);
        chk("par_clr", perr_b, 0);

        // five writes into a depth-4 FIFO
        for (int i = 0; i < 5; i++) send_b(8'h31 + 8'(i));
        repeat (5) @(negedge clk);
        chk("ovr_full", full_b, 1);
        chk("ovr_count", cnt_b, 4);
        chk("ovr_flag", ovr_b, 1);
        chk("ovr_perr", perr_b, 0);
        for (int i = 0; i < 4; i++) pop(1);
        chk("ovr_popn", q_b.size(), 5);
        for (int i = 0; i < 4; i++) chk($sformatf("ovr_pop%0d", i), q_b[1+i], 8'h31 + 8'(i));
        chk("ovr_empty", emp_b, 1);
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        @(negedge clk);
        chk("ovr_clr", ovr_b, 0);

        // pop lands on the 5th write edge: start at N0, final stop sample at edge 3+8+10*16
        for (int i = 0; i < 4; i++) send_b(8'h41 + 8'(i));
        fork
            send_b(8'h45);
            begin
                repeat (170) @(negedge clk);
                rd_en_b = 1'b1;
                @(negedge clk);
                rd_en_b = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        chk("sim_ovr", ovr_b, 0);
        chk("sim_count", cnt_b, 4);
        chk("sim_full", full_b, 1);
        chk("sim_pop41", q_b[5], 8'h41);
        for (int i = 0; i < 4; i++) pop(1);
        for (int i = 0; i < 4; i++) chk($sformatf("sim_pop%0d", i), q_b[6+i], 8'h42 + 8'(i));

        // 7 data bits, 2 stop bits, reset mid-frame
        send(2, mk(8'h7F, 7, 0, 1'b0, 2, 1'b1), 10, 16);
        repeat (5) @(negedge clk);
        chk("c_udata7f", udata_c, 8'h7F);
        chk("c_count1", cnt_c, 1);
        d0 = dn_c;
        fork
            send(2, mk(8'h55, 7, 0, 1'b0, 2, 1'b1), 10, 16);
            begin
                repeat (72) @(negedge clk);
                rst_c_n = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        rst_c_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("c_rst_done", dn_c, d0);
        chk("c_rst_count", cnt_c, 0);
        chk("c_rst_empty", emp_c, 1);
        chk("c_rst_outs", {rd_data_c, udata_c, rv_c, full_c, done_c, ferr_c, perr_c, ovr_c}, 0);
        send(2, mk(8'h12, 7, 0, 1'b0, 2, 1'b1), 10, 16);
        repeat (5) @(negedge clk);
        chk("c_done12", dn_c, d0 + 1);
        chk("c_udata12", udata_c, 8'h12);
        chk("c_count12", cnt_c, 1);
        pop(2);
        chk("c_pop12", q_c[0], 8'h12);
        chk("c_flags", {ferr_c, perr_c, ovr_c}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo_mon.md
Name: uart_rx_fifo_mon

Overview:
Parametrised successor to the fixed 8N1 UART receive monitor used on the SoC bench. It deserialises uart_rxd with configurable frame format, checks start, parity and stop bits, and buffers received characters in a FIFO with a read handshake. It raises sticky error flags and can optionally echo each character to the simulator console. It sits on the SoC uart_tx_pin, on the bench or as a synthesisable debug receiver.

Parameters:
CLK_FREQ, 50000000, sys_clk frequency in Hz.
BAUD, 115200, line rate; BIT_CNT = CLK_FREQ/BAUD (integer truncation), HALF_CNT = BIT_CNT/2.
DATA_BITS, 8, data bits per frame; legal range 5..8.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
FIFO_DEPTH, 16, entries; power of two, at least 2; AW = log2(FIFO_DEPTH).
PRINT_EN, 0, 1 = $write each accepted character (simulation-only code, excluded from synthesis).

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  asynchronous active-low reset
uart_rxd  in  1  serial line, idle high
rd_en  in  1  pop request
clr_err  in  1  clears all sticky error flags
rd_data  out  8  popped character, zero-extended above DATA_BITS
rd_valid  out  1  one-cycle strobe: rd_data is valid
fifo_count  out  AW+1  current occupancy
fifo_empty  out  1  fifo_count == 0
fifo_full  out  1  fifo_count == FIFO_DEPTH
uart_done  out  1  one-cycle pulse when a frame completes (good or bad)
uart_data  out  8  last completed frame's data, held until the next frame completes
frame_err  out  1  sticky: stop bit sampled low
parity_err  out  1  sticky: parity mismatch
overrun  out  1  sticky: good character dropped because FIFO full

Behaviour:
- Reset (async assert, sync release): FSM = IDLE; FIFO pointers and count = 0. All outputs 0 except fifo_empty = 1. The rxd synchroniser resets to 1.
- uart_rxd passes through a 2-FF synchroniser, then a registered copy for edge detect. A start is a 1->0 transition of the synchronised line in IDLE.
- FSM states: IDLE, START, DATA, PAR, STOP1, STOP2.
- Bit counter:
  - START samples at HALF_CNT.
  - Each later bit samples BIT_CNT cycles after the previous sample, i.e. at mid-bit.
- Transitions:
  - START, sampled line high -> false start, back to IDLE with no flags and no uart_done.
  - START, sampled line low -> DATA.
  - DATA: DATA_BITS samples, LSB first. Then PAR if PARITY != 0, else STOP1.
  - PAR: compare the sampled bit with the expected value (XOR of data, inverted for odd).
  - STOP1: if STOP_BITS == 2 -> STOP2, else complete the frame.
  - STOP2: complete the frame.
- Frame completion:
  - Fires on the cycle of the final stop sample; FSM returns to IDLE that same cycle and re-arms immediately for back-to-back frames.
  - uart_done pulses and uart_data updates.
  - A low stop sample (either stop bit) sets frame_err; the character is discarded, not written.
  - A parity mismatch sets parity_err; the character is still written.
  - A good character with fifo_full sets overrun; the character is dropped and FIFO contents are unchanged.
- Read side:
  - rd_en with !fifo_empty pops the head. rd_data is registered; rd_valid is high the following cycle.
  - rd_en while empty is ignored: no strobe, no pointer change.
- A write and a pop in the same cycle leave count unchanged. When full, the pop is honoured and the write accepted; no overrun.
- Pointers wrap modulo FIFO_DEPTH.
- clr_err clears all three sticky flags. If clr_err coincides with a new error event, the flag stays set.
- Reset mid-frame aborts the frame with no write and no uart_done.
- PRINT_EN = 1: $write("%c") on each FIFO write.

Test Plan:
- 50 MHz, 115200, 8N1: send 0x55 then 0xA3 back-to-back -> two uart_done pulses, 434 clocks per bit; after two pops rd_data = 0x55 then 0xA3, fifo_count 2 -> 0.
- 3-cycle low glitch on uart_rxd in IDLE -> no uart_done, no flags, fifo_empty stays 1.
- PARITY=2: send 0x07 with parity bit 0 (wrong) -> parity_err = 1, 0x07 in FIFO; pulse clr_err -> parity_err = 0.
- Send 0x41 with stop bit forced low -> uart_done pulses, frame_err = 1, fifo_count stays 0.
- FIFO_DEPTH=4: send 5 characters with no reads -> fifo_full = 1, overrun = 1, pops return the first four. Repeat with rd_en asserted on the 5th write cycle -> no overrun.
- DATA_BITS=7, STOP_BITS=2: send 0x7F; assert sys_rst_n low during bit 3 of a following frame -> after reset, all outputs at reset values, and the next frame 0x12 is received correctly.
